// File: rtl/freq_meter_pkg.sv
// Shared constants and helpers for the freq_meter slice.
package freq_meter_pkg;

  localparam int unsigned SYNC_STAGES = 2;

  // Low bit of channel k's field in a flat vector of w-bit fields.
  function automatic int unsigned slice_lo(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Synchroniser for one asynchronous input followed by a rising-edge detector.
module edge_sync
  import freq_meter_pkg::*;
(
  input  logic sys_clk,
  input  logic reset,
  input  logic clear,
  input  logic in_async,
  output logic out_edge
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // The synchroniser keeps sampling through clear; only the edge history is dropped.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_async};
      prev_q <= clear ? 1'b0 : sync_q[SYNC_STAGES-1];
    end
  end

  assign out_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Multi-channel gated edge counter; publishes all counts once per window.
// Define FREQ_METER_OVF_EN for saturating counters with per-channel overflow flags.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned PERIOD_W = 32
) (
  input  logic                      sys_clk,
  input  logic                      reset,
  input  logic                      in_enable,
  input  logic [PERIOD_W-1:0]       in_period,
  input  logic [CHANNELS-1:0]       in_ext_clk,
  output logic [CHANNELS*CNT_W-1:0] out_count,
  output logic                      out_valid,
  output logic [CHANNELS-1:0]       out_overflow
);

  logic [PERIOD_W-1:0] period_eff;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] gate_q;
  logic                terminal;
  logic                valid_q;
  logic [CHANNELS-1:0] edge_v;
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];
  logic [CNT_W-1:0]    pub_q [CHANNELS];

  assign period_eff = (in_period == '0) ? PERIOD_W'(1) : in_period;
  assign terminal   = (gate_q == period_q - PERIOD_W'(1));

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    edge_sync u_edge_sync (
      .sys_clk  (sys_clk),
      .reset    (reset),
      .clear    (~in_enable),
      .in_async (in_ext_clk[k]),
      .out_edge (edge_v[k])
    );
    assign out_count[slice_lo(k, CNT_W) +: CNT_W] = pub_q[k];
  end

`ifdef FREQ_METER_OVF_EN
  logic [CHANNELS-1:0] sat_hit;
  logic [CHANNELS-1:0] ovf_q;
  logic [CHANNELS-1:0] ovf_pub_q;

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      sat_hit[k] = edge_v[k] & (cnt_q[k] == '1);
      cnt_d[k]   = sat_hit[k] ? cnt_q[k] : cnt_q[k] + CNT_W'(edge_v[k]);
    end
  end

  // Window-sticky flag; this cycle's hit is folded in when publishing.
  always_ff @(posedge sys_clk) begin
    if (reset || !in_enable || terminal) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_q | sat_hit;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      ovf_pub_q <= '0;
    end else if (in_enable && terminal) begin
      ovf_pub_q <= ovf_q | sat_hit;
    end
  end

  assign out_overflow = ovf_pub_q;
`else
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      cnt_d[k] = cnt_q[k] + CNT_W'(edge_v[k]);
    end
  end

  assign out_overflow = '0;
`endif

  // Terminal cycle publishes count plus this cycle's edge, so nothing is lost at the seam.
  always_ff @(posedge sys_clk) begin
    if (reset || !in_enable) begin
      period_q <= period_eff;
      gate_q   <= '0;
      valid_q  <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        cnt_q[k] <= '0;
        if (reset) begin
          pub_q[k] <= '0;
        end
      end
    end else if (terminal) begin
      period_q <= period_eff;
      gate_q   <= '0;
      valid_q  <= 1'b1;
      for (int k = 0; k < CHANNELS; k++) begin
        pub_q[k] <= cnt_d[k];
        cnt_q[k] <= '0;
      end
    end else begin
      gate_q  <= gate_q + PERIOD_W'(1);
      valid_q <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign out_valid = valid_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter with a cycle model feeding an expected-result queue.
module tb_freq_meter;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int PW  = 16;

  typedef struct {
    logic [NCH*CW-1:0] cnt;
    logic [NCH-1:0]    ovf;
  } exp_t;

  logic              sys_clk;
  logic              reset;
  logic              in_enable;
  logic [PW-1:0]     in_period;
  logic [NCH-1:0]    in_ext_clk;
  logic [NCH*CW-1:0] out_count;
  logic              out_valid;
  logic [NCH-1:0]    out_overflow;
  logic              e0, e1, e2, e3;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_vcyc = 0;
  int gap    = 0;
  int tog_ph = 0;
  logic tog2 = 1'b0;

  // Model state
  exp_t              exp_q [$];
  logic [NCH-1:0]    m_s0, m_s1, m_pv;
  int                m_gate, m_per;
  int                m_acc [NCH];
  logic              m_valid;
  logic [NCH*CW-1:0] m_last;
  logic [NCH-1:0]    m_lovf;

  assign in_ext_clk = {e3, e2, e1, e0};

  freq_meter #(
    .CHANNELS (NCH),
    .CNT_W    (CW),
    .PERIOD_W (PW)
  ) dut (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .in_enable    (in_enable),
    .in_period    (in_period),
    .in_ext_clk   (in_ext_clk),
    .out_count    (out_count),
    .out_valid    (out_valid),
    .out_overflow (out_overflow)
  );

  initial begin
    sys_clk = 1'b0;
    forever #20 sys_clk = ~sys_clk;
  end

  // 1 MHz and 2.5 MHz against a 25 MHz sys_clk, offset away from clock edges
  initial begin
    e0 = 1'b0;
    #7;
    forever #500 e0 = ~e0;
  end

  initial begin
    e1 = 1'b0;
    #7;
    forever #200 e1 = ~e1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    assert (got === want)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h required %0h", tag, got, want);
    end
  endtask

  task automatic model_step();
    logic [NCH-1:0] rises;
    exp_t e;
    int peff;
    peff = (in_period == 0) ? 1 : int'(in_period);
    cyc++;
    m_valid = 1'b0;
    if (reset) begin
      m_s0 = '0; m_s1 = '0; m_pv = '0;
      m_gate = 0; m_per = peff;
      m_acc = '{default: 0};
      m_last = '0; m_lovf = '0;
      exp_q.delete();
    end else begin
      rises = m_s1 & ~m_pv;
      if (!in_enable) begin
        m_gate = 0; m_per = peff;
        m_acc = '{default: 0};
        m_pv = '0;
      end else begin
        for (int k = 0; k < NCH; k++) if (rises[k]) m_acc[k]++;
        if (m_gate == m_per - 1) begin
          e.cnt = '0;
          e.ovf = '0;
          for (int k = 0; k < NCH; k++) begin
`ifdef FREQ_METER_OVF_EN
            if (m_acc[k] > 255) begin
              e.cnt[k*CW +: CW] = 8'hff;
              e.ovf[k] = 1'b1;
            end else begin
              e.cnt[k*CW +: CW] = 8'(m_acc[k]);
            end
`else
            e.cnt[k*CW +: CW] = 8'(m_acc[k]);
`endif
          end
          exp_q.push_back(e);
          m_valid = 1'b1;
          m_acc = '{default: 0};
          m_gate = 0;
          m_per = peff;
        end else begin
          m_gate++;
        end
        m_pv = m_s1;
      end
      m_s1 = m_s0;
      m_s0 = in_ext_clk;
    end
  endtask

  task automatic check_cycle();
    exp_t e;
    chk("valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      n_vec++;
      assert (exp_q.size() > 0)
      else begin
        n_fail++;
        $error("FAIL sb_empty: got 0 entries required 1");
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        m_last = e.cnt;
        m_lovf = e.ovf;
      end
    end
    chk("count", 64'(out_count), 64'(m_last));
    chk("ovf", 64'(out_overflow), 64'(m_lovf));
  endtask

  task automatic tick();
    if (tog2) begin
      if (tog_ph == 0) e2 = ~e2;
      tog_ph = 1 - tog_ph;
    end
    @(posedge sys_clk);
    model_step();
    @(negedge sys_clk);
    check_cycle();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < budget);
    chk(tag, 64'(out_valid), 64'd1);
    gap = cyc - last_vcyc;
    last_vcyc = cyc;
  endtask

  initial begin
    logic [NCH*CW-1:0] held;
    int c, sum;
    int w3 [$];

    reset = 1'b1; in_enable = 1'b1; in_period = 16'd1000;
    e2 = 1'b0; e3 = 1'b0;
    ticks(4);
    chk("rst_count", 64'(out_count), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ovf", 64'(out_overflow), 64'd0);

    // Steady 1 MHz / 2.5 MHz over 1000-cycle windows
    reset = 1'b0;
    last_vcyc = cyc;
    wait_valid(1100, "w1_valid");
    chk("w1_gap", 64'(gap), 64'd1000);
    c = int'(out_count[7:0]);
    chk("w1_ch0_near40", 64'(c >= 39 && c <= 41), 64'd1);
    c = int'(out_count[15:8]);
    chk("w1_ch1_near100", 64'(c >= 99 && c <= 101), 64'd1);
    wait_valid(1100, "w2_valid");
    chk("w2_gap", 64'(gap), 64'd1000);
    chk("w2_ch0", 64'(out_count[7:0]), 64'd40);
    chk("w2_ch1", 64'(out_count[15:8]), 64'd100);
    wait_valid(1100, "w3_valid");
    chk("w3_ch0", 64'(out_count[7:0]), 64'd40);

    // Period change mid-window takes effect from the next window
    ticks(300);
    in_period = 16'd500;
    wait_valid(1100, "pc_a");
    chk("pc_gap_old", 64'(gap), 64'd1000);
    wait_valid(600, "pc_b");
    chk("pc_gap_new", 64'(gap), 64'd500);
    in_period = 16'd1000;
    wait_valid(600, "pc_c");
    chk("pc_gap_c", 64'(gap), 64'd500);
    wait_valid(1100, "pc_d");
    chk("pc_gap_d", 64'(gap), 64'd1000);

    // Enable dropped mid-window discards it and restarts a full window
    ticks(600);
    held = out_count;
    in_enable = 1'b0;
    ticks(50);
    chk("dis_hold", 64'(out_count), 64'(held));
    in_enable = 1'b1;
    last_vcyc = cyc;
    wait_valid(1100, "en_valid");
    chk("en_gap", 64'(gap), 64'd1000);

    // Edges counted on the terminal cycle and on the first cycle of the next window
    in_period = 16'd20;
    wait_valid(1100, "p20_a");
    wait_valid(40, "p20_b");
    chk("p20_gap", 64'(gap), 64'd20);
    c = cyc;
    for (int i = 0; i < 65; i++) begin
      if (cyc == c + 17) e3 = 1'b1;
      if (cyc == c + 19) e3 = 1'b0;
      if (cyc == c + 38) e3 = 1'b1;
      if (cyc == c + 40) e3 = 1'b0;
      tick();
      if (out_valid) w3.push_back(int'(out_count[31:24]));
    end
    chk("seam_nwin", 64'(w3.size()), 64'd3);
    if (w3.size() == 3) begin
      chk("seam_term", 64'(w3[0]), 64'd1);
      chk("seam_mid", 64'(w3[1]), 64'd0);
      chk("seam_after", 64'(w3[2]), 64'd1);
      chk("seam_sum", 64'(w3[0] + w3[1] + w3[2]), 64'd2);
    end

    // Period 0 behaves as 1: a window every cycle
    in_period = 16'd0;
    wait_valid(30, "p0_valid");
    tog2 = 1'b1;
    sum = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      chk("p0_every", 64'(out_valid), 64'd1);
      if (i >= 8) begin
        sum += int'(out_count[23:16]);
        chk("p0_01", 64'(out_count[23:16] <= 8'd1), 64'd1);
      end
    end
    chk("p0_sum", 64'(sum), 64'd4);
    in_period = 16'd1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("p1_every", 64'(out_valid), 64'd1);
    end

    // 275 edges into an 8-bit counter
    in_period = 16'd1100;
    wait_valid(5, "ov_a");
    wait_valid(1200, "ov_b");
    chk("ov_gap", 64'(gap), 64'd1100);
    chk("ov_ch0", 64'(out_count[7:0]), 64'd44);
    chk("ov_ch1", 64'(out_count[15:8]), 64'd110);
    chk("ov_ch3", 64'(out_count[31:24]), 64'd0);
`ifdef FREQ_METER_OVF_EN
    chk("ov_ch2", 64'(out_count[23:16]), 64'd255);
    chk("ov_flag", 64'(out_overflow), 64'b0100);
`else
    chk("ov_ch2", 64'(out_count[23:16]), 64'd19);
    chk("ov_flag", 64'(out_overflow), 64'd0);
`endif

    // Reset mid-window
    ticks(300);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    reset = 1'b1;
    tick();
    chk("mrst_count", 64'(out_count), 64'd0);
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_ovf", 64'(out_overflow), 64'd0);
    reset = 1'b0;
    ticks(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
